anton_neopixel_stream_decoder: RTL

ANTON_NEOPIXEL_STREAM_DECODER -- requirements
Module: anton_neopixel_stream_decoder

---
 rtl/anton_neopixel_stream_decoder.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/anton_neopixel_stream_decoder.sv
// NeoPixel (WS2812-style) serial stream decoder: turns pulse widths on the
// data line into 24-bit pixels with frame boundaries, a per-frame pixel count
// and sticky error flags.

`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 255
`endif
`ifndef RESET_DELAY_DEFAULT
`define RESET_DELAY_DEFAULT 320
`endif

module anton_neopixel_stream_decoder #(
  parameter int unsigned BUFFER_END  = `BUFFER_END_DEFAULT,
  parameter int unsigned RESET_DELAY = `RESET_DELAY_DEFAULT,
  localparam int unsigned BUFFER_BITS = $clog2(BUFFER_END + 1)
) (
  input  logic                   clk6_4mhz,
  input  logic                   rstn,
  input  logic                   streamInput,
  input  logic                   enable,
  output logic                   pixelValid,
  output logic [23:0]            pixelData,
  output logic [BUFFER_BITS-1:0] pixelIndex,
  output logic                   frameDone,
  output logic [BUFFER_BITS:0]   pixelCount,
  output logic [2:0]             errorFlags,
  output logic [1:0]             state
);

  localparam int unsigned COUNT_BITS = BUFFER_BITS + 1;
  localparam int unsigned LOW_BITS   = 12;
  localparam int unsigned HIGH_BITS  = 4;
  localparam int unsigned BIT_BITS   = 5;

  localparam logic [1:0] SYNC  = 2'd0;
  localparam logic [1:0] LOW   = 2'd1;
  localparam logic [1:0] HIGH  = 2'd2;
  localparam logic [1:0] ERROR = 2'd3;

  localparam logic [LOW_BITS-1:0]    RESET_LIMIT = LOW_BITS'(RESET_DELAY);
  localparam logic [HIGH_BITS-1:0]   HIGH_STUCK  = HIGH_BITS'(7);
  localparam logic [HIGH_BITS-1:0]   HIGH_ONE    = HIGH_BITS'(4);
  localparam logic [BIT_BITS-1:0]    LAST_BIT    = BIT_BITS'(23);
  localparam logic [COUNT_BITS-1:0]  COUNT_MAX   = '1;
  localparam logic [COUNT_BITS-1:0]  LAST_SLOT   = COUNT_BITS'(BUFFER_END);
  localparam logic [COUNT_BITS-1:0]  OVERFLOW_AT = COUNT_BITS'(BUFFER_END + 1);
  localparam logic [BUFFER_BITS-1:0] INDEX_LAST  = BUFFER_BITS'(BUFFER_END);

  logic                   syncMeta;
  logic                   s;
  logic [LOW_BITS-1:0]    lowCount;
  logic [HIGH_BITS-1:0]   highCount;
  logic [23:0]            shiftReg;
  logic [BIT_BITS-1:0]    bitIndex;
  logic [COUNT_BITS-1:0]  frameCount;

  logic [1:0]             stateNext;
  logic [LOW_BITS-1:0]    lowCountNext;
  logic [HIGH_BITS-1:0]   highCountNext;
  logic [23:0]            shiftNext;
  logic [BIT_BITS-1:0]    bitIndexNext;
  logic [COUNT_BITS-1:0]  frameCountNext;
  logic [BUFFER_BITS-1:0] pixelIndexNext;
  logic                   pixelValidNext;
  logic [23:0]            pixelDataNext;
  logic                   frameDoneNext;
  logic [COUNT_BITS-1:0]  pixelCountNext;
  logic [2:0]             errorFlagsNext;

  logic                   bitDecoded;
  logic                   bitValue;
  logic                   frameEnd;
  logic [LOW_BITS-1:0]    lowCountInc;
  logic [HIGH_BITS-1:0]   highCountInc;

  // Two-flop synchronizer for the asynchronous data line
  always_ff @(posedge clk6_4mhz or negedge rstn) begin
    if (!rstn) begin
      syncMeta <= 1'b0;
      s        <= 1'b0;
    end else begin
      syncMeta <= streamInput;
      s        <= syncMeta;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk6_4mhz or negedge rstn) begin
    if (!rstn) begin
      state      <= SYNC;
      lowCount   <= '0;
      highCount  <= '0;
      shiftReg   <= '0;
      bitIndex   <= '0;
      frameCount <= '0;
      pixelIndex <= '0;
      pixelValid <= 1'b0;
      pixelData  <= '0;
      frameDone  <= 1'b0;
      pixelCount <= '0;
      errorFlags <= '0;
    end else begin
      state      <= stateNext;
      lowCount   <= lowCountNext;
      highCount  <= highCountNext;
      shiftReg   <= shiftNext;
      bitIndex   <= bitIndexNext;
      frameCount <= frameCountNext;
      pixelIndex <= pixelIndexNext;
      pixelValid <= pixelValidNext;
      pixelData  <= pixelDataNext;
      frameDone  <= frameDoneNext;
      pixelCount <= pixelCountNext;
      errorFlags <= errorFlagsNext;
    end
  end

  // Pulse-width decode, pixel assembly and frame bookkeeping
  always_comb begin
    stateNext      = state;
    lowCountNext   = lowCount;
    highCountNext  = highCount;
    shiftNext      = shiftReg;
    bitIndexNext   = bitIndex;
    frameCountNext = frameCount;
    pixelIndexNext = pixelIndex;
    pixelValidNext = 1'b0;
    pixelDataNext  = pixelData;
    frameDoneNext  = 1'b0;
    pixelCountNext = pixelCount;
    errorFlagsNext = errorFlags;
    bitDecoded     = 1'b0;
    bitValue       = 1'b0;
    frameEnd       = 1'b0;
    lowCountInc    = (lowCount == RESET_LIMIT) ? lowCount : lowCount + LOW_BITS'(1);
    highCountInc   = (highCount == '1) ? highCount : highCount + HIGH_BITS'(1);

    // The presented index moves on one tick after each emitted pixel
    if (pixelValid && (pixelIndex != INDEX_LAST)) begin
      pixelIndexNext = pixelIndex + BUFFER_BITS'(1);
    end

    case (state)
      SYNC: begin
        if (!s) begin
          lowCountNext = lowCountInc;
          if (lowCountInc == RESET_LIMIT) begin
            stateNext = LOW;
          end
        end else begin
          lowCountNext = '0;
        end
      end
      LOW: begin
        if (s) begin
          stateNext     = HIGH;
          highCountNext = HIGH_BITS'(1);
          lowCountNext  = '0;
        end else begin
          lowCountNext = lowCountInc;
          // Fire only on the tick the count first reaches the limit
          if ((lowCount != RESET_LIMIT) && (lowCountInc == RESET_LIMIT)) begin
            frameEnd = 1'b1;
          end
        end
      end
      HIGH: begin
        if (s) begin
          highCountNext = highCountInc;
          if (highCountInc == HIGH_STUCK) begin
            stateNext         = ERROR;
            errorFlagsNext[0] = 1'b1;
            shiftNext         = '0;
            bitIndexNext      = '0;
          end
        end else begin
          bitDecoded    = 1'b1;
          bitValue      = (highCount >= HIGH_ONE);
          stateNext     = LOW;
          lowCountNext  = LOW_BITS'(1);
          highCountNext = '0;
        end
      end
      default: begin
        if (!s) begin
          stateNext     = SYNC;
          lowCountNext  = LOW_BITS'(1);
          highCountNext = '0;
        end else begin
          highCountNext = highCountInc;
        end
      end
    endcase

    // Shift in the decoded bit; the 24th bit completes a pixel
    if (bitDecoded) begin
      shiftNext = (shiftReg << 1) | 24'(bitValue);
      if (bitIndex == LAST_BIT) begin
        bitIndexNext = '0;
        if (frameCount != COUNT_MAX) begin
          frameCountNext = frameCount + COUNT_BITS'(1);
        end
        if (frameCount <= LAST_SLOT) begin
          pixelValidNext = 1'b1;
          pixelDataNext  = (shiftReg << 1) | 24'(bitValue);
        end else begin
          errorFlagsNext[2] = 1'b1;
        end
      end else begin
        bitIndexNext = bitIndex + BIT_BITS'(1);
      end
    end

    // Frame close: report count, replace sticky flags with this frame's
    if (frameEnd) begin
      frameDoneNext  = 1'b1;
      pixelCountNext = frameCount;
      errorFlagsNext = {(frameCount > OVERFLOW_AT), (bitIndex != '0), 1'b0};
      shiftNext      = '0;
      bitIndexNext   = '0;
      frameCountNext = '0;
      pixelIndexNext = '0;
    end

    // Disabled decoder idles in SYNC with everything but the reports cleared
    if (!enable) begin
      stateNext      = SYNC;
      lowCountNext   = '0;
      highCountNext  = '0;
      shiftNext      = '0;
      bitIndexNext   = '0;
      frameCountNext = '0;
      pixelIndexNext = '0;
      pixelValidNext = 1'b0;
      frameDoneNext  = 1'b0;
      pixelDataNext  = pixelData;
      pixelCountNext = pixelCount;
      errorFlagsNext = errorFlags;
    end
  end

endmodule
